// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC generation, req/gnt/rvalid bus master and
// in-order response buffer feeding the IF/ID register.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o
);

   localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   localparam logic [1:0] S_RESET = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] kill_q, kill_d;
   logic [CW-1:0] rcnt_q, rcnt_d;
   logic [PW-1:0] awp_q, arp_q, rwp_q, rrp_q;
   logic [31:0]   last_q;

   logic [31:0] afifo_q [DEPTH];
   logic [31:0] raddr_q [DEPTH];
   logic [31:0] rdata_q [DEPTH];

   logic          jump, credit, hs;
   logic          kill_rv, acc_rv, head_v, pop;
   logic [CW:0]   used, kill_sum;

   always_comb begin
      jump     = jump_en_i && (state_q != S_RESET);
      used     = {1'b0, out_q} + {1'b0, rcnt_q};
      credit   = used < DEPTH_W;
      ibus_req_o = (state_q == S_RUN) && !jump_en_i && credit;
      hs       = ibus_req_o && ibus_gnt_i;
      kill_rv  = ibus_rvalid_i && (kill_q != '0);
      acc_rv   = ibus_rvalid_i && (kill_q == '0)
                 && (out_q != '0) && !jump;
      head_v   = rcnt_q != '0;
      pop      = head_v && !hold_flag_i && !jump;
      // requests still in flight at a jump become kills; one may land now
      kill_sum = {1'b0, kill_q} + {1'b0, out_q}
                 - (CW+1)'(ibus_rvalid_i
                           && ((kill_q != '0) || (out_q != '0)));
   end

   assign ibus_addr_o  = pc_q;
   assign inst_valid_o = head_v;
   assign inst_o       = head_v ? rdata_q[rrp_q] : INST_NOP;
   assign inst_addr_o  = head_v ? raddr_q[rrp_q] : last_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      out_d   = out_q;
      kill_d  = kill_q;
      rcnt_d  = rcnt_q;
      unique case (state_q)
         S_RESET: state_d = S_RUN;
         S_RUN, S_DRAIN: begin
            if (jump) begin
               pc_d    = jump_addr_i & ~32'h3;
               out_d   = '0;
               rcnt_d  = '0;
               kill_d  = kill_sum[CW-1:0];
               state_d = (kill_sum != '0) ? S_DRAIN : S_RUN;
            end else begin
               if (hs) pc_d = pc_q + 32'd4;
               out_d  = out_q + CW'(hs) - CW'(acc_rv);
               rcnt_d = rcnt_q + CW'(acc_rv) - CW'(pop);
               if (kill_rv) kill_d = kill_q - CW'(1);
               if (state_q == S_DRAIN && kill_d == '0)
                  state_d = S_RUN;
            end
         end
         default: state_d = S_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RESET;
         pc_q    <= RESET_PC;
         out_q   <= '0;
         kill_q  <= '0;
         rcnt_q  <= '0;
         awp_q   <= '0;
         arp_q   <= '0;
         rwp_q   <= '0;
         rrp_q   <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         kill_q  <= kill_d;
         rcnt_q  <= rcnt_d;
         if (head_v) last_q <= raddr_q[rrp_q];
         if (jump) begin
            awp_q <= '0;
            arp_q <= '0;
            rwp_q <= '0;
            rrp_q <= '0;
         end else begin
            if (hs)     awp_q <= awp_q + PW'(1);
            if (acc_rv) arp_q <= arp_q + PW'(1);
            if (acc_rv) rwp_q <= rwp_q + PW'(1);
            if (pop)    rrp_q <= rrp_q + PW'(1);
         end
      end
   end

   // payload storage needs no reset; counters qualify every read
   always_ff @(posedge clk) begin
      if (hs) afifo_q[awp_q] <= pc_q;
      if (acc_rv) begin
         raddr_q[rwp_q] <= afifo_q[arp_q];
         rdata_q[rwp_q] <= ibus_rdata_i;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: bus responder model plus in-order scoreboard
// of granted fetch addresses against the IF/ID output stream.
module tb_ifu_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        hold_flag_i;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i;
   logic        ibus_rvalid_i;
   logic [31:0] ibus_rdata_i;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_valid_o;

   int total = 0;
   int bad   = 0;
   logic rv_en;
   logic [31:0] pcm;
   logic [31:0] exp_q[$];
   logic [31:0] pend_q[$];
   logic [31:0] seen[$];

   ifu_fetch #(
      .RESET_PC(RESET_PC),
      .DEPTH(DEPTH),
      .INST_NOP(NOP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .jump_en_i(jump_en_i),
      .jump_addr_i(jump_addr_i),
      .hold_flag_i(hold_flag_i),
      .ibus_req_o(ibus_req_o),
      .ibus_addr_o(ibus_addr_o),
      .ibus_gnt_i(ibus_gnt_i),
      .ibus_rvalid_i(ibus_rvalid_i),
      .ibus_rdata_i(ibus_rdata_i),
      .inst_o(inst_o),
      .inst_addr_o(inst_addr_o),
      .inst_valid_o(inst_valid_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // one clock: monitor at negedge, then drive bus responses after posedge
   task automatic step();
      logic hs;
      @(negedge clk);
      if (rst) begin
         exp_q.delete();
         pend_q.delete();
         pcm = RESET_PC;
      end else begin
         hs = ibus_req_o && ibus_gnt_i;
         if (ibus_rvalid_i) void'(pend_q.pop_front());
         total++;
         if (inst_valid_o) begin
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected addr=%h inst=%h required=none",
                        inst_addr_o, inst_o);
            end else begin
               if (inst_addr_o !== exp_q[0] || inst_o !== mem(exp_q[0])) begin
                  bad++;
                  $display("FAIL sb_head addr=%h inst=%h required %h/%h",
                           inst_addr_o, inst_o, exp_q[0], mem(exp_q[0]));
               end
               if (!hold_flag_i && !jump_en_i) begin
                  seen.push_back(exp_q[0]);
                  void'(exp_q.pop_front());
               end
            end
         end else if (inst_o !== NOP) begin
            bad++;
            $display("FAIL sb_nop inst=%h required %h", inst_o, NOP);
         end
         if (hs) begin
            total++;
            if (ibus_addr_o !== pcm) begin
               bad++;
               $display("FAIL req_addr addr=%h required %h", ibus_addr_o, pcm);
            end
            pend_q.push_back(ibus_addr_o);
            exp_q.push_back(ibus_addr_o);
            pcm = pcm + 32'd4;
         end
         if (jump_en_i) begin
            total++;
            if (ibus_req_o !== 1'b0) begin
               bad++;
               $display("FAIL req_on_jump req=%b required 0", ibus_req_o);
            end
            exp_q.delete();
            pcm = jump_addr_i & ~32'h3;
         end
         total++;
         if (exp_q.size() > DEPTH) begin
            bad++;
            $display("FAIL credit unconsumed=%0d required<=%0d",
                     exp_q.size(), DEPTH);
         end
      end
      @(posedge clk);
      #1;
      ibus_rvalid_i = !rst && rv_en && (pend_q.size() > 0);
      ibus_rdata_i  = ibus_rvalid_i ? mem(pend_q[0]) : 32'h0;
   endtask

   task automatic wait_seen(input int n, input string nm);
      for (int i = 0; i < 40; i++) begin
         if (seen.size() >= n) break;
         step();
      end
      total++;
      if (seen.size() < n) begin
         bad++;
         $display("FAIL %s_timeout seen=%0d required %0d", nm, seen.size(), n);
      end
   endtask

   task automatic check_reset_outs(input string nm);
      total++;
      if (ibus_req_o !== 1'b0 || ibus_addr_o !== RESET_PC ||
          inst_valid_o !== 1'b0 || inst_o !== NOP ||
          inst_addr_o !== 32'h0) begin
         bad++;
         $display("FAIL %s req=%b addr=%h v=%b inst=%h ia=%h required 0/%h/0/%h/0",
                  nm, ibus_req_o, ibus_addr_o, inst_valid_o, inst_o,
                  inst_addr_o, RESET_PC, NOP);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      check_reset_outs("reset_outs");
      rst = 1'b0;
      total++;
      if (ibus_req_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_first_cycle req=%b required 0", ibus_req_o);
      end
      step();
      total++;
      if (ibus_req_o !== 1'b1 || ibus_addr_o !== RESET_PC) begin
         bad++;
         $display("FAIL reset_restart req=%b addr=%h required 1/%h",
                  ibus_req_o, ibus_addr_o, RESET_PC);
      end
   endtask

   task automatic test_stream();
      int n;
      n = seen.size();
      step();
      total++;
      if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h4) begin
         bad++;
         $display("FAIL stream_consec req=%b addr=%h required 1/4",
                  ibus_req_o, ibus_addr_o);
      end
      step();
      total++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) begin
         bad++;
         $display("FAIL stream_latency v=%b ia=%h required 1/0",
                  inst_valid_o, inst_addr_o);
      end
      wait_seen(n + 3, "stream");
      total++;
      if (seen.size() >= n + 3 &&
          (seen[n] !== 32'h0 || seen[n+1] !== 32'h4 || seen[n+2] !== 32'h8)) begin
         bad++;
         $display("FAIL stream_order got %h %h %h required 0 4 8",
                  seen[n], seen[n+1], seen[n+2]);
      end
   endtask

   task automatic test_hold();
      logic [31:0] hi, ha;
      int n;
      hold_flag_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (inst_valid_o) break;
      end
      hi = inst_o;
      ha = inst_addr_o;
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if (inst_o !== hi || inst_addr_o !== ha || inst_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL hold_frozen inst=%h ia=%h required %h/%h",
                     inst_o, inst_addr_o, hi, ha);
         end
      end
      total++;
      if (ibus_req_o !== 1'b0 || exp_q.size() != DEPTH) begin
         bad++;
         $display("FAIL hold_credit req=%b unconsumed=%0d required 0/%0d",
                  ibus_req_o, exp_q.size(), DEPTH);
      end
      n = seen.size();
      hold_flag_i = 1'b0;
      wait_seen(n + 4, "hold_resume");
      total++;
      if (seen.size() >= n + 4 && seen[n] !== ha) begin
         bad++;
         $display("FAIL hold_first got %h required %h", seen[n], ha);
      end
      for (int i = n; i + 1 < seen.size(); i++) begin
         total++;
         if (seen[i+1] !== seen[i] + 32'd4) begin
            bad++;
            $display("FAIL hold_seq got %h after %h required %h",
                     seen[i+1], seen[i], seen[i] + 32'd4);
         end
      end
   endtask

   task automatic fill_outstanding(input string nm);
      rv_en = 1'b0;
      for (int i = 0; i < 6; i++) step();
      total++;
      if (pend_q.size() != 2) begin
         bad++;
         $display("FAIL %s_outstanding got %0d required 2", nm, pend_q.size());
      end
   endtask

   task automatic test_jump();
      int n;
      fill_outstanding("jump");
      jump_en_i   = 1'b1;
      jump_addr_i = 32'h0000_1002;
      step();
      jump_en_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (ibus_req_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== NOP) begin
            bad++;
            $display("FAIL jump_drain req=%b v=%b inst=%h required 0/0/%h",
                     ibus_req_o, inst_valid_o, inst_o, NOP);
         end
      end
      rv_en = 1'b1;
      n = seen.size();
      for (int i = 0; i < 10; i++) begin
         step();
         if (ibus_req_o) break;
      end
      total++;
      if (ibus_req_o !== 1'b1 || pend_q.size() != 0 ||
          ibus_addr_o !== 32'h0000_1000) begin
         bad++;
         $display("FAIL jump_target req=%b stale=%0d addr=%h required 1/0/1000",
                  ibus_req_o, pend_q.size(), ibus_addr_o);
      end
      wait_seen(n + 1, "jump");
      total++;
      if (seen.size() > n && seen[n] !== 32'h0000_1000) begin
         bad++;
         $display("FAIL jump_first got %h required 00001000", seen[n]);
      end
   endtask

   task automatic test_jump_rvalid();
      int n;
      fill_outstanding("jrv");
      rv_en = 1'b1;
      step();
      jump_en_i   = 1'b1;
      jump_addr_i = 32'h0000_2000;
      step();
      jump_en_i = 1'b0;
      total++;
      if (ibus_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL jrv_drain req=%b v=%b required 0/0",
                  ibus_req_o, inst_valid_o);
      end
      n = seen.size();
      step();
      total++;
      if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0000_2000) begin
         bad++;
         $display("FAIL jrv_kill1 req=%b addr=%h required 1/2000",
                  ibus_req_o, ibus_addr_o);
      end
      wait_seen(n + 1, "jrv");
      total++;
      if (seen.size() > n && seen[n] !== 32'h0000_2000) begin
         bad++;
         $display("FAIL jrv_first got %h required 00002000", seen[n]);
      end
   endtask

   task automatic test_gnt_stall();
      logic [31:0] a0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (ibus_req_o) break;
      end
      ibus_gnt_i = 1'b0;
      a0 = ibus_addr_o;
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (ibus_req_o !== 1'b1 || ibus_addr_o !== a0) begin
            bad++;
            $display("FAIL gnt_stall req=%b addr=%h required 1/%h",
                     ibus_req_o, ibus_addr_o, a0);
         end
      end
      ibus_gnt_i = 1'b1;
      step();
      total++;
      if (ibus_addr_o !== a0 + 32'd4) begin
         bad++;
         $display("FAIL gnt_advance addr=%h required %h", ibus_addr_o, a0 + 32'd4);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      hold_flag_i = 1'b1;
      for (int i = 0; i < 8; i++) step();
      total++;
      if (inst_valid_o !== 1'b1 || ibus_req_o !== 1'b0) begin
         bad++;
         $display("FAIL rmid_full v=%b req=%b required 1/0",
                  inst_valid_o, ibus_req_o);
      end
      rst = 1'b1;
      step();
      check_reset_outs("rmid_outs");
      rst = 1'b0;
      hold_flag_i = 1'b0;
      total++;
      if (ibus_req_o !== 1'b0) begin
         bad++;
         $display("FAIL rmid_first req=%b required 0", ibus_req_o);
      end
      step();
      total++;
      if (ibus_req_o !== 1'b1 || ibus_addr_o !== RESET_PC) begin
         bad++;
         $display("FAIL rmid_restart req=%b addr=%h required 1/%h",
                  ibus_req_o, ibus_addr_o, RESET_PC);
      end
      n = seen.size();
      wait_seen(n + 1, "rmid");
      total++;
      if (seen.size() > n && seen[n] !== RESET_PC) begin
         bad++;
         $display("FAIL rmid_first_inst got %h required %h", seen[n], RESET_PC);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         hold_flag_i = ($urandom_range(0, 3) == 0);
         ibus_gnt_i  = ($urandom_range(0, 3) != 0);
         rv_en       = ($urandom_range(0, 2) != 0);
         jump_en_i   = ($urandom_range(0, 24) == 0);
         jump_addr_i = $urandom;
         step();
      end
      jump_en_i   = 1'b0;
      hold_flag_i = 1'b0;
      ibus_gnt_i  = 1'b1;
      rv_en       = 1'b1;
      for (int i = 0; i < 10; i++) step();
      total++;
      if (pend_q.size() > DEPTH) begin
         bad++;
         $display("FAIL rand_pending got %0d required<=%0d", pend_q.size(), DEPTH);
      end
   endtask

   initial begin
      rst           = 1'b1;
      jump_en_i     = 1'b0;
      jump_addr_i   = 32'h0;
      hold_flag_i   = 1'b0;
      ibus_gnt_i    = 1'b1;
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = 32'h0;
      rv_en         = 1'b1;
      pcm           = RESET_PC;
      test_reset();
      test_stream();
      test_hold();
      test_jump();
      test_jump_rvalid();
      test_gnt_stall();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
